// File: rtl/ngc_counter_bank_pkg.sv
// Shared types for the counter bank: channel modes and the bounce phase encoding.
package ngc_counter_bank_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    WRAP     = 2'd0,
    ONE_SHOT = 2'd1,
    BOUNCE   = 2'd2,
    RSVD     = 2'd3
  } mode_e;

  // Bounce direction state: forward steps along dir, reverse steps against it.
  typedef enum logic {
    PH_FWD = 1'b0,
    PH_REV = 1'b1
  } phase_e;

endpackage

// File: rtl/ngc_counter_bank_if.sv
// Configuration/status bundle between the peripheral register block (master)
// and the counter bank (slave).
interface ngc_counter_bank_if #(
  parameter int WIDTH      = 16,
  parameter int CHANNELS   = 4,
  parameter int PRESCALE_W = 8
);
  import ngc_counter_bank_pkg::*;

  // No valid/ready handshake: every input is a level sampled on each posedge
  // clk, and every output is valid whenever read (hit is combinational).
  logic [PRESCALE_W-1:0]              prescale;
  logic [CHANNELS-1:0]                enb;
  logic [CHANNELS-1:0]                dir;
  logic [CHANNELS-1:0][MODE_W-1:0]    mode;
  logic [CHANNELS-1:0]                load;
  logic [CHANNELS-1:0][WIDTH-1:0]     load_value;
  logic [CHANNELS-1:0][WIDTH-1:0]     from_value;
  logic [CHANNELS-1:0][WIDTH-1:0]     to_value;
  logic [CHANNELS-1:0][WIDTH-1:0]     step_value;
  logic [CHANNELS-1:0]                irq_mask;
  logic [CHANNELS-1:0]                status_clr;

  logic [CHANNELS-1:0][WIDTH-1:0]     count;
  logic [CHANNELS-1:0]                hit;
  logic [CHANNELS-1:0]                term_event;
  logic [CHANNELS-1:0]                done;
  logic [CHANNELS-1:0]                status;
  logic [CHANNELS-1:0]                phase;
  logic                               irq;

  modport master (
    output prescale, enb, dir, mode, load, load_value, from_value,
           to_value, step_value, irq_mask, status_clr,
    input  count, hit, term_event, done, status, phase, irq
  );

  modport slave (
    input  prescale, enb, dir, mode, load, load_value, from_value,
           to_value, step_value, irq_mask, status_clr,
    output count, hit, term_event, done, status, phase, irq
  );

endinterface

// File: rtl/ngc_counter_bank_ch.sv
// One counter channel: count, bounce phase, one-shot done, event pulse and
// sticky status. Advances only on cycles where the shared tick is high.
module ngc_counter_bank_ch
  import ngc_counter_bank_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              enb,
  input  logic              dir,
  input  logic [MODE_W-1:0] mode,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_value,
  input  logic [WIDTH-1:0]  from_value,
  input  logic [WIDTH-1:0]  to_value,
  input  logic [WIDTH-1:0]  step_value,
  input  logic              status_clr,
  output logic [WIDTH-1:0]  count,
  output logic              hit,
  output logic              term_event,
  output logic              done,
  output logic              status,
  output logic              phase
);

  logic [WIDTH-1:0] count_q, count_d;
  phase_e           phase_q, phase_d;
  logic             done_q, done_d;
  logic             event_q, event_d;
  logic             status_q, status_d;

  logic [WIDTH-1:0] up_v;
  logic [WIDTH-1:0] dn_v;
  logic [WIDTH-1:0] fwd_v;
  logic [WIDTH-1:0] rev_v;
  logic             at_to;
  logic             at_from;
  logic             step_en;
  mode_e            mode_v;

  assign mode_v  = mode_e'(mode);
  assign at_to   = (count_q == to_value);
  assign at_from = (count_q == from_value);
  assign step_en = enb && tick && !done_q;

  // Modulo arithmetic: overflow and underflow simply wrap.
  assign up_v  = count_q + step_value;
  assign dn_v  = count_q - step_value;
  assign fwd_v = dir ? dn_v : up_v;
  assign rev_v = dir ? up_v : dn_v;

  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    done_d  = done_q;
    event_d = 1'b0;

    if (load) begin
      count_d = load_value;
      phase_d = PH_FWD;
      done_d  = 1'b0;
    end else if (step_en) begin
      case (mode_v)
        ONE_SHOT: begin
          if (at_to) begin
            done_d  = 1'b1;
            event_d = 1'b1;
          end else begin
            count_d = fwd_v;
          end
        end
        BOUNCE: begin
          if (phase_q == PH_FWD) begin
            if (at_to) begin
              count_d = rev_v;
              phase_d = PH_REV;
              event_d = 1'b1;
            end else begin
              count_d = fwd_v;
            end
          end else begin
            // Reverse leg turns at from_value; a hit on the way still reports.
            if (at_from) begin
              count_d = fwd_v;
              phase_d = PH_FWD;
              event_d = 1'b1;
            end else begin
              count_d = rev_v;
              event_d = at_to;
            end
          end
        end
        default: begin
          if (at_to) begin
            count_d = from_value;
            event_d = 1'b1;
          end else begin
            count_d = fwd_v;
          end
        end
      endcase
    end

    // A new event beats a clear arriving in the same cycle.
    status_d = event_d | (status_q & ~status_clr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q  <= from_value;
      phase_q  <= PH_FWD;
      done_q   <= 1'b0;
      event_q  <= 1'b0;
      status_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      phase_q  <= phase_d;
      done_q   <= done_d;
      event_q  <= event_d;
      status_q <= status_d;
    end
  end

  assign count      = count_q;
  assign hit        = at_to;
  assign term_event = event_q;
  assign done       = done_q;
  assign status     = status_q;
  assign phase      = phase_q;

endmodule

// File: rtl/ngc_counter_bank.sv
// Counter bank top: shared prescaler, per-channel counters and the registered
// masked interrupt reduction.
module ngc_counter_bank
  import ngc_counter_bank_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int CHANNELS   = 4,
  parameter int PRESCALE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  ngc_counter_bank_if.slave bus
);

  logic [PRESCALE_W-1:0]          psc_cnt;
  logic                           tick;
  logic                           irq_q;

  logic [CHANNELS-1:0][WIDTH-1:0] count_w;
  logic [CHANNELS-1:0]            hit_w;
  logic [CHANNELS-1:0]            event_w;
  logic [CHANNELS-1:0]            done_w;
  logic [CHANNELS-1:0]            status_w;
  logic [CHANNELS-1:0]            phase_w;

  // >= rather than == so lowering prescale mid-run never skips a tick window.
  assign tick = (psc_cnt >= bus.prescale);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      psc_cnt <= '0;
    end else if (tick) begin
      psc_cnt <= '0;
    end else begin
      psc_cnt <= psc_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    ngc_counter_bank_ch #(
      .WIDTH (WIDTH)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (tick),
      .enb        (bus.enb[i]),
      .dir        (bus.dir[i]),
      .mode       (bus.mode[i]),
      .load       (bus.load[i]),
      .load_value (bus.load_value[i]),
      .from_value (bus.from_value[i]),
      .to_value   (bus.to_value[i]),
      .step_value (bus.step_value[i]),
      .status_clr (bus.status_clr[i]),
      .count      (count_w[i]),
      .hit        (hit_w[i]),
      .term_event (event_w[i]),
      .done       (done_w[i]),
      .status     (status_w[i]),
      .phase      (phase_w[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |(status_w & bus.irq_mask);
    end
  end

  assign bus.count      = count_w;
  assign bus.hit        = hit_w;
  assign bus.term_event = event_w;
  assign bus.done       = done_w;
  assign bus.status     = status_w;
  assign bus.phase      = phase_w;
  assign bus.irq        = irq_q;

endmodule

// File: tb/tb_ngc_counter_bank.sv
// Directed plus randomized bench for ngc_counter_bank with a cycle-level
// behavioural model of every channel, the prescaler and the interrupt.
module tb_ngc_counter_bank;

  localparam int W    = 8;
  localparam int N    = 4;
  localparam int PW   = 8;
  localparam int MASK = (1 << W) - 1;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  ngc_counter_bank_if #(.WIDTH(W), .CHANNELS(N), .PRESCALE_W(PW)) bus ();

  ngc_counter_bank #(
    .WIDTH      (W),
    .CHANNELS   (N),
    .PRESCALE_W (PW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

  // Reference state, updated once per clock from the documented rules.
  int m_count  [N];
  int m_phase  [N];
  int m_done   [N];
  int m_evt    [N];
  int m_status [N];
  int m_irq;
  int m_psc;

  task automatic chk(input string tag, input int ch, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s ch%0d observed=%0h expected=%0h", tag, ch, obs, exp);
    end
  endtask

  task automatic model_update();
    int tick, any, e, c, s, f, fwd, rev;
    if (!rst_n) begin
      m_psc = 0;
      m_irq = 0;
      for (int i = 0; i < N; i++) begin
        m_count[i]  = int'(bus.from_value[i]);
        m_phase[i]  = 0;
        m_done[i]   = 0;
        m_evt[i]    = 0;
        m_status[i] = 0;
      end
    end else begin
      tick = (m_psc >= int'(bus.prescale)) ? 1 : 0;
      any = 0;
      for (int i = 0; i < N; i++)
        if (m_status[i] != 0 && bus.irq_mask[i]) any = 1;
      m_irq = any;
      m_psc = tick ? 0 : m_psc + 1;
      for (int i = 0; i < N; i++) begin
        e = 0;
        c = m_count[i];
        s = int'(bus.step_value[i]);
        f = int'(bus.from_value[i]);
        fwd = bus.dir[i] ? ((c - s) & MASK) : ((c + s) & MASK);
        rev = bus.dir[i] ? ((c + s) & MASK) : ((c - s) & MASK);
        if (bus.load[i]) begin
          m_count[i] = int'(bus.load_value[i]);
          m_done[i]  = 0;
          m_phase[i] = 0;
        end else if (bus.enb[i] && tick == 1 && m_done[i] == 0) begin
          if (c == int'(bus.to_value[i])) e = 1;
          if (bus.mode[i] == 2'd1) begin
            if (e == 1) m_done[i] = 1;
            else m_count[i] = fwd;
          end else if (bus.mode[i] == 2'd2) begin
            if (m_phase[i] == 0) begin
              if (e == 1) begin
                m_count[i] = rev;
                m_phase[i] = 1;
              end else begin
                m_count[i] = fwd;
              end
            end else if (c == f) begin
              m_count[i] = fwd;
              m_phase[i] = 0;
              e = 1;
            end else begin
              m_count[i] = rev;
            end
          end else begin
            m_count[i] = (e == 1) ? f : fwd;
          end
        end
        m_evt[i] = e;
        if (e == 1) m_status[i] = 1;
        else if (bus.status_clr[i]) m_status[i] = 0;
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < N; i++) begin
      chk("count",  i, 32'(bus.count[i]),      32'(m_count[i]));
      chk("hit",    i, 32'(bus.hit[i]),
          (m_count[i] == int'(bus.to_value[i])) ? 32'd1 : 32'd0);
      chk("event",  i, 32'(bus.term_event[i]), 32'(m_evt[i]));
      chk("done",   i, 32'(bus.done[i]),       32'(m_done[i]));
      chk("status", i, 32'(bus.status[i]),     32'(m_status[i]));
      chk("phase",  i, 32'(bus.phase[i]),      32'(m_phase[i]));
    end
    chk("irq", 0, 32'(bus.irq), 32'(m_irq));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      model_update();
      @(posedge clk);
      #1;
      compare_all();
    end
  endtask

  task automatic set_ch(input int i, input int md, input int d, input int f,
                        input int t, input int s);
    bus.mode[i]       = 2'(md);
    bus.dir[i]        = 1'(d);
    bus.from_value[i] = W'(f);
    bus.to_value[i]   = W'(t);
    bus.step_value[i] = W'(s);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    bus.prescale   = '0;
    bus.enb        = '0;
    bus.dir        = '0;
    bus.mode       = '0;
    bus.load       = '0;
    bus.load_value = '0;
    bus.irq_mask   = '0;
    bus.status_clr = '0;
    for (int i = 0; i < N; i++) set_ch(i, 0, 0, 0, 200, 1);

    // Reset state and WRAP up 0..5 at prescale 0.
    set_ch(0, 0, 0, 0, 5, 1);
    run(2);
    chk("rst_count", 0, 32'(bus.count[0]), 32'd0);
    chk("rst_irq", 0, 32'(bus.irq), 32'd0);
    chk("rst_status", 0, 32'(bus.status), 32'd0);
    rst_n = 1'b1;
    bus.enb[0] = 1'b1;
    run(5);
    chk("wrap_top", 0, 32'(bus.count[0]), 32'd5);
    chk("wrap_hit", 0, 32'(bus.hit[0]), 32'd1);
    run(1);
    chk("wrap_back", 0, 32'(bus.count[0]), 32'd0);
    chk("wrap_event", 0, 32'(bus.term_event[0]), 32'd1);
    run(1);
    chk("wrap_ev_pulse", 0, 32'(bus.term_event[0]), 32'd0);
    chk("wrap_sticky", 0, 32'(bus.status[0]), 32'd1);
    run(5);
    chk("wrap_event2", 0, 32'(bus.term_event[0]), 32'd1);
    bus.status_clr[0] = 1'b1;
    run(1);
    chk("status_clr", 0, 32'(bus.status[0]), 32'd0);
    bus.status_clr[0] = 1'b0;
    bus.enb[0] = 1'b0;

    // WRAP down by 2 from 10 to 4 with prescale 3.
    bus.prescale = 8'd3;
    set_ch(1, 0, 1, 10, 4, 2);
    rst_n = 1'b0;
    run(1);
    rst_n = 1'b1;
    bus.enb[1] = 1'b1;
    run(3);
    chk("psc_hold", 1, 32'(bus.count[1]), 32'd10);
    run(1);
    chk("psc_first", 1, 32'(bus.count[1]), 32'd8);
    run(8);
    chk("down_to", 1, 32'(bus.count[1]), 32'd4);
    run(4);
    chk("down_wrap", 1, 32'(bus.count[1]), 32'd10);
    chk("down_event", 1, 32'(bus.term_event[1]), 32'd1);
    bus.enb[1] = 1'b0;
    bus.prescale = 8'd0;

    // ONE_SHOT up 0..3, then reload from 1.
    set_ch(2, 1, 0, 0, 3, 1);
    bus.load[2] = 1'b1;
    bus.load_value[2] = 8'd0;
    run(1);
    bus.load[2] = 1'b0;
    bus.enb[2] = 1'b1;
    run(4);
    chk("os_count", 2, 32'(bus.count[2]), 32'd3);
    chk("os_done", 2, 32'(bus.done[2]), 32'd1);
    chk("os_event", 2, 32'(bus.term_event[2]), 32'd1);
    run(3);
    chk("os_stopped", 2, 32'(bus.count[2]), 32'd3);
    chk("os_no_event", 2, 32'(bus.term_event[2]), 32'd0);
    bus.load[2] = 1'b1;
    bus.load_value[2] = 8'd1;
    run(1);
    chk("os_reload", 2, 32'(bus.count[2]), 32'd1);
    chk("os_undone", 2, 32'(bus.done[2]), 32'd0);
    bus.load[2] = 1'b0;
    run(3);
    chk("os_done2", 2, 32'(bus.done[2]), 32'd1);
    bus.enb[2] = 1'b0;

    // BOUNCE up between 2 and 5.
    set_ch(3, 2, 0, 2, 5, 1);
    bus.load[3] = 1'b1;
    bus.load_value[3] = 8'd2;
    run(1);
    bus.load[3] = 1'b0;
    bus.enb[3] = 1'b1;
    run(4);
    chk("bnc_turn_top", 3, 32'(bus.count[3]), 32'd4);
    chk("bnc_event_top", 3, 32'(bus.term_event[3]), 32'd1);
    run(3);
    chk("bnc_turn_bot", 3, 32'(bus.count[3]), 32'd3);
    chk("bnc_event_bot", 3, 32'(bus.term_event[3]), 32'd1);
    bus.enb[3] = 1'b0;

    // Load beats a ticking step at hit; set beats clear.
    bus.load[0] = 1'b1;
    bus.load_value[0] = 8'd5;
    run(1);
    bus.enb[0] = 1'b1;
    bus.load_value[0] = 8'd9;
    run(1);
    chk("load_wins", 0, 32'(bus.count[0]), 32'd9);
    chk("load_no_event", 0, 32'(bus.term_event[0]), 32'd0);
    bus.load_value[0] = 8'd5;
    run(1);
    bus.load[0] = 1'b0;
    bus.status_clr[0] = 1'b1;
    run(1);
    chk("set_wins", 0, 32'(bus.status[0]), 32'd1);
    bus.status_clr[0] = 1'b0;

    // Reset mid-count overrides load and step.
    bus.from_value[0] = 8'd7;
    bus.load[0] = 1'b1;
    bus.load_value[0] = 8'd3;
    rst_n = 1'b0;
    run(1);
    chk("rst_mid_count", 0, 32'(bus.count[0]), 32'd7);
    chk("rst_mid_irq", 0, 32'(bus.irq), 32'd0);
    rst_n = 1'b1;
    bus.load[0] = 1'b0;
    bus.enb = '0;

    // Masked interrupt follows only channel 2.
    bus.irq_mask = 4'b0100;
    set_ch(0, 0, 0, 0, 1, 1);
    set_ch(2, 0, 0, 0, 1, 1);
    bus.load = 4'b0101;
    bus.load_value[0] = 8'd1;
    bus.load_value[2] = 8'd1;
    run(1);
    bus.load = '0;
    bus.enb = 4'b0101;
    run(1);
    chk("irq_status", 0, 32'(bus.status), 32'b0101);
    chk("irq_lag_rise", 0, 32'(bus.irq), 32'd0);
    bus.enb = '0;
    run(1);
    chk("irq_rise", 0, 32'(bus.irq), 32'd1);
    bus.status_clr = 4'b0100;
    run(1);
    chk("irq_lag_fall", 0, 32'(bus.irq), 32'd1);
    bus.status_clr = '0;
    run(1);
    chk("irq_fall", 0, 32'(bus.irq), 32'd0);
    chk("irq_ch0_kept", 0, 32'(bus.status[0]), 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < N; i++)
      set_ch(i, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 7),
             $urandom_range(4, 15), $urandom_range(1, 3));
    for (int k = 0; k < 600; k++) begin
      rst_n = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 49) == 0) bus.prescale = PW'($urandom_range(0, 3));
      bus.irq_mask = N'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        bus.enb[i]        = ($urandom_range(0, 3) != 0);
        bus.dir[i]        = ($urandom_range(0, 7) == 0) ? ~bus.dir[i] : bus.dir[i];
        bus.load[i]       = ($urandom_range(0, 29) == 0);
        bus.load_value[i] = W'($urandom_range(0, 15));
        bus.status_clr[i] = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 39) == 0)
          set_ch(i, $urandom_range(0, 3), bus.dir[i], $urandom_range(0, 7),
                 $urandom_range(4, 15), $urandom_range(1, 3));
      end
      run(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ngc_counter_bank.md
# ngc_counter_bank

Multi-channel, parametrised counter/timer bank: the next generation of the team's single up/down counter. Provides CHANNELS independent counters of WIDTH bits sharing one programmable prescaler. Each channel has wrap, one-shot and bounce modes, sticky terminal-count status and a masked, aggregated interrupt. It sits beside the peripheral register block, which drives its configuration inputs and reads status.

## Interface
- WIDTH, 16, counter width in bits (>= 2)
- CHANNELS, 4, number of independent channels (>= 1)
- PRESCALE_W, 8, prescaler setting width
- clk  in  1  single clock, all logic on posedge
- rst_n  in  1  synchronous, active-low reset
- prescale  in  PRESCALE_W  shared tick divider; a tick occurs every prescale+1 cycles
- enb  in  [CHANNELS]  per-channel count enable
- dir  in  [CHANNELS]  0 = count up (+step), 1 = count down (-step)
- mode  in  [CHANNELS][2]  0 WRAP, 1 ONE_SHOT, 2 BOUNCE, 3 reserved (behaves as WRAP)
- load  in  [CHANNELS]  load count from load_value
- load_value, from_value, to_value, step_value  in  [CHANNELS][WIDTH]  per-channel values
- irq_mask  in  [CHANNELS]  1 = channel contributes to irq
- status_clr  in  [CHANNELS]  clear sticky status bit
- count  out  [CHANNELS][WIDTH]  registered count
- hit  out  [CHANNELS]  combinational, count == to_value
- event  out  [CHANNELS]  registered 1-cycle pulse on terminal-count event
- done  out  [CHANNELS]  ONE_SHOT channel stopped
- status  out  [CHANNELS]  sticky event flags
- irq  out  1  registered OR of status & irq_mask

## Operation
- Prescaler: free-running psc_cnt. tick = (psc_cnt >= prescale), and psc_cnt clears on tick, otherwise increments. prescale = 0 gives a tick every cycle. The >= compare makes a mid-run decrease of prescale safe.
- Per-channel priority, highest first: reset, load, (!enb or !tick) hold, done hold, count step.
- load: acts in the same cycle regardless of tick or enb. Sets count <= load_value, done <= 0, phase <= 0.
- Step cycle (enb && tick && !done):
  - WRAP, !hit: count <= count ± step_value. WRAP, hit: count <= from_value.
  - ONE_SHOT, hit: count holds and done <= 1. Otherwise it steps as in WRAP.
  - BOUNCE: internal phase bit. With phase 0, count steps in direction dir. At hit, count steps in the opposite direction and phase <= 1. With phase 1, count steps opposite to dir. At count == from_value, count steps in direction dir and phase <= 0.
- Terminal event: any step cycle with hit true in any mode, plus the phase-1 count == from_value turn in BOUNCE. A done channel generates no further events.
- Arithmetic is modulo 2^WIDTH. There is no saturation. hit is equality only, so a step that jumps over to_value never hits and wraps naturally.
- status[i]: set by event[i] and cleared by status_clr[i]. If set and clear occur in the same cycle, set wins.
- mode or dir changes take effect at the next step. phase is not cleared on a mode change.

## Timing
- Reset (rst_n = 0 at a clk edge) gives:
  - count = from_value (sampled at that edge)
  - psc_cnt = 0; phase, done, event, status and irq = 0
  - Reset mid-operation overrides load and step in the same cycle.
- count updates 1 cycle after the enabling edge. hit follows count combinationally.
- event pulses in the cycle after the terminal step edge, coincident with the updated count.
- status rises together with event. irq rises 1 cycle after status and falls 1 cycle after status or its mask bit clears.
- With prescale = P, an enabled channel advances exactly once per P+1 cycles. The first tick after reset comes at cycle P+1.

## Structure
- ngc_counter_bank_pkg: mode_e enum (WRAP, ONE_SHOT, BOUNCE, RSVD) and the mode width constant.
- Sub-module ngc_counter_bank_ch: one channel, holding count, phase, done, event and status. It is instantiated CHANNELS times in a generate loop.
- The top level holds the prescaler, the tick fan-out and the irq reduction register.

## Test plan
- WIDTH=8, prescale=0, WRAP up, from=0, to=5, step=1 -> count sequence 0..5,0,1. event pulses once per 6 cycles. status stays set until status_clr.
- prescale=3, WRAP down, from=10, to=4, step=2 -> count changes every 4 cycles: 10,8,6,4,10. The event coincides with the second 10.
- ONE_SHOT up, from=0, to=3 -> count stops at 3 and done=1. Further ticks cause no change. load with load_value=1 clears done and counting resumes from 1.
- BOUNCE up, from=2, to=5, step=1 -> count sequence 2,3,4,5,4,3,2,3. Events occur at the 5→4 and 2→3 turns.
- Simultaneous stimulus: load and tick at hit -> load wins. event and status_clr in the same cycle -> status stays 1. rst_n low during a count -> count = from_value next edge, irq = 0.
- Four channels with irq_mask=0b0100 and events on channels 0 and 2 -> irq only follows status[2], with a one-cycle lag after both set and clear.
